// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module : lsu_mem_initiator
// Brief  : Load/store initiator; range-checks requests, splits misaligned
//          half/word accesses into byte accesses, extends load data.
// Rev    : 1.0
// ============================================================================
module lsu_mem_initiator #(
  parameter logic [31:0] BASE_ADDR        = 32'h0100_0000,
  parameter int unsigned MEM_BYTES        = 1048576,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic        mem_is_sign,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [32:0] c_last_addr = {1'b0, BASE_ADDR} + 33'(MEM_BYTES) - 33'd1;

  state_t      r_state;
  state_t      w_next;
  logic        r_ready;
  logic        r_store;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic [1:0]  r_idx;
  logic [1:0]  r_last;
  logic [31:0] r_asm;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [1:0]  r_mem_size;
  logic        r_resp_valid;
  logic        r_resp_fault;
  logic [31:0] r_resp_rdata;

  logic [1:0]  w_last;
  logic [32:0] w_end;
  logic        w_misal;
  logic        w_fault;
  logic        w_accept;
  logic [1:0]  w_idx_n;
  logic [7:0]  w_next_byte;
  logic [31:0] w_load_raw;
  logic [31:0] w_load_ext;

  // Range check uses 33 bits so an address sum that wraps past 2^32 also faults.
  always_comb begin
    w_last = 2'd3;
    if (req_size == 2'b00) w_last = 2'd0;
    else if (req_size == 2'b01) w_last = 2'd1;
  end

  assign w_end    = {1'b0, req_addr} + {31'b0, w_last};
  assign w_misal  = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_fault  = (req_size == 2'b11) || (req_addr < BASE_ADDR) ||
                    (w_end > c_last_addr) || (w_misal && !SPLIT_MISALIGNED);
  assign w_accept = req_valid && r_ready;

  assign w_idx_n     = r_idx + 2'd1;
  assign w_next_byte = r_wdata[8*w_idx_n +: 8];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_fault)      w_next = RESP;
          else if (w_misal) w_next = SPLIT;
          else              w_next = ACCESS;
        end
      end
      ACCESS:  w_next = RESP;
      SPLIT:   if (r_idx == r_last) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Load value as it stands at the closing edge, including the byte on the bus now.
  always_comb begin
    w_load_raw = r_asm;
    if (r_state == ACCESS) w_load_raw = mem_data_out;
    else                   w_load_raw[8*r_idx +: 8] = mem_data_out[7:0];
  end

  always_comb begin
    case (r_size)
      2'b00:   w_load_ext = {{24{r_signed & w_load_raw[7]}},  w_load_raw[7:0]};
      2'b01:   w_load_ext = {{16{r_signed & w_load_raw[15]}}, w_load_raw[15:0]};
      default: w_load_ext = w_load_raw;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_store      <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= 2'b00;
      r_wdata      <= '0;
      r_idx        <= 2'd0;
      r_last       <= 2'd0;
      r_asm        <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_size   <= 2'b00;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_next;
      r_ready      <= (w_next == IDLE);
      r_resp_valid <= (w_next == RESP);
      r_resp_fault <= w_accept && w_fault;
      r_resp_rdata <= '0;
      if ((w_next == RESP) && !r_store && ((r_state == ACCESS) || (r_state == SPLIT)))
        r_resp_rdata <= w_load_ext;

      if (w_accept) begin
        r_store  <= req_store;
        r_signed <= req_signed;
        r_size   <= req_size;
        r_wdata  <= req_wdata;
        r_idx    <= 2'd0;
        r_last   <= w_last;
        r_asm    <= '0;
        if (!w_fault) begin
          r_mem_addr  <= req_addr;
          r_mem_size  <= w_misal ? 2'b00 : req_size;
          r_mem_wdata <= w_misal ? {24'b0, req_wdata[7:0]} : req_wdata;
        end
      end

      if (r_state == SPLIT) begin
        r_asm <= w_load_raw;
        if (r_idx != r_last) begin
          r_idx       <= w_idx_n;
          r_mem_addr  <= r_mem_addr + 32'd1;
          r_mem_wdata <= {24'b0, w_next_byte};
        end
      end
    end
  end

  assign req_ready       = r_ready;
  assign resp_valid      = r_resp_valid;
  assign resp_fault      = r_resp_fault;
  assign resp_rdata      = r_resp_rdata;
  assign mem_address     = r_mem_addr;
  assign mem_data_in     = r_mem_wdata;
  assign mem_access_size = r_mem_size;
  assign mem_read_write  = r_store && ((r_state == ACCESS) || (r_state == SPLIT));
  assign mem_is_sign     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// Testbench for lsu_mem_initiator: byte memory model plus response scoreboard.
module tb_lsu_mem_initiator;

  localparam logic [31:0] c_base = 32'h0100_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  typedef struct {
    bit          ns;
    logic        st;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] rd;
    logic        f;
    int          lat;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, req_valid, ns_req_valid, req_store, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        req_ready, resp_valid, resp_fault, mem_read_write, mem_is_sign;
  logic [31:0] resp_rdata, mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_access_size;

  logic        ns_req_ready, ns_resp_valid, ns_resp_fault, ns_mem_read_write, ns_mem_is_sign;
  logic [31:0] ns_resp_rdata, ns_mem_address, ns_mem_data_in;
  logic [1:0]  ns_mem_access_size;

  lsu_mem_initiator dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_read_write(mem_read_write),
    .mem_is_sign(mem_is_sign), .mem_access_size(mem_access_size), .mem_data_out(mem_data_out)
  );

  lsu_mem_initiator #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clock(clock), .reset_n(reset_n),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_fault(ns_resp_fault),
    .mem_address(ns_mem_address), .mem_data_in(ns_mem_data_in), .mem_read_write(ns_mem_read_write),
    .mem_is_sign(ns_mem_is_sign), .mem_access_size(ns_mem_access_size), .mem_data_out(32'h0)
  );

  // 256-byte window at c_base; reads outside it return 0, writes outside are dropped.
  logic [7:0]  mem [0:255];
  logic [31:0] off0, off1, off2, off3;
  logic [7:0]  rb0, rb1, rb2, rb3;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_off, pl_data;
  int          wr_count = 0, ns_wr_count = 0, cyc = 0, acc_cyc = 0;
  logic [1:0]  last_wr_size = 2'b00;

  assign off0 = mem_address - c_base;
  assign off1 = off0 + 32'd1;
  assign off2 = off0 + 32'd2;
  assign off3 = off0 + 32'd3;
  assign rb0  = (off0 < 32'd256) ? mem[off0[7:0]] : 8'h00;
  assign rb1  = (off1 < 32'd256) ? mem[off1[7:0]] : 8'h00;
  assign rb2  = (off2 < 32'd256) ? mem[off2[7:0]] : 8'h00;
  assign rb3  = (off3 < 32'd256) ? mem[off3[7:0]] : 8'h00;
  assign mem_data_out = (mem_access_size == 2'b00) ? {24'h0, rb0} :
                        (mem_access_size == 2'b01) ? {16'h0, rb1, rb0} :
                        (mem_access_size == 2'b10) ? {rb3, rb2, rb1, rb0} : 32'h0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_off] <= pl_data;
    if (mem_read_write) begin
      wr_count     <= wr_count + 1;
      last_wr_size <= mem_access_size;
      if (off0 < 32'd256) mem[off0[7:0]] <= mem_data_in[7:0];
      if (mem_access_size != 2'b00 && off1 < 32'd256) mem[off1[7:0]] <= mem_data_in[15:8];
      if (mem_access_size == 2'b10 && off2 < 32'd256) mem[off2[7:0]] <= mem_data_in[23:16];
      if (mem_access_size == 2'b10 && off3 < 32'd256) mem[off3[7:0]] <= mem_data_in[31:24];
    end
    if (ns_mem_read_write) ns_wr_count <= ns_wr_count + 1;
  end

  int   total = 0, bad = 0;
  exp_t sb[$];

  task automatic preload(input int o, input logic [7:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_off = o[7:0]; pl_data = d;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    int guard = 0;
    @(negedge clock);
    while (!(v.ns ? ns_req_ready : req_ready) && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    req_store = v.st; req_addr = v.a; req_wdata = v.wd; req_size = v.sz; req_signed = v.sg;
    if (v.ns) ns_req_valid = 1'b1; else req_valid = 1'b1;
    sb.push_back('{v.rd, v.f, v.lat});
    @(posedge clock); #1;
    req_valid = 1'b0; ns_req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_resp(input bit ns, output bit got, output logic [31:0] rd,
                           output logic flt, output int lat);
    got = 1'b0; rd = '0; flt = 1'b0; lat = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clock);
      if (ns ? ns_resp_valid : resp_valid) begin
        got = 1'b1;
        rd  = ns ? ns_resp_rdata : resp_rdata;
        flt = ns ? ns_resp_fault : resp_fault;
        lat = cyc - acc_cyc + 1;
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0]  ctl;
    logic [95:0] dat;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    ctl = {req_ready, resp_valid, resp_fault, mem_read_write, mem_is_sign, mem_access_size,
           ns_req_ready, ns_resp_valid, ns_mem_read_write};
    dat = {resp_rdata, mem_address, mem_data_in};
    total++;
    if (ctl !== 10'b0) begin bad++; $display("FAIL reset_ctl: got %b want 0", ctl); end
    total++;
    if (dat !== 96'b0) begin bad++; $display("FAIL reset_data: got %h want 0", dat); end
    reset_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", req_ready); end
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge: got %b want 1", req_ready); end
  endtask

  task automatic test_aligned();
    bit got; logic [31:0] rd; logic flt; int lat; exp_t e; int w0;
    w0 = wr_count;
    issue('{1'b0, 1'b1, 32'h0100_0004, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0, 2});
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_busy: got %b want 0", req_ready); end
    wait_resp(1'b0, got, rd, flt, lat);
    e = sb.pop_front();
    total++;
    if (!got || rd !== e.rdata || flt !== e.fault || lat != e.lat) begin
      bad++; $display("FAIL word_store: got v=%b rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", got, rd, flt, lat, e.rdata, e.fault, e.lat);
    end
    total++;
    if (wr_count - w0 != 1 || last_wr_size !== 2'b10) begin
      bad++; $display("FAIL word_store_cycles: got writes=%0d size=%b want 1 10", wr_count - w0, last_wr_size);
    end
    total++;
    if ({mem[7], mem[6], mem[5], mem[4]} !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL word_store_mem: got %h want deadbeef", {mem[7], mem[6], mem[5], mem[4]});
    end
    issue('{1'b0, 1'b0, 32'h0100_0004, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 2});
    wait_resp(1'b0, got, rd, flt, lat);
    e = sb.pop_front();
    total++;
    if (!got || rd !== e.rdata || flt !== e.fault || lat != e.lat || mem_is_sign !== 1'b0) begin
      bad++; $display("FAIL word_load: got v=%b rd=%h f=%b lat=%0d sign=%b want rd=%h f=%b lat=%0d", got, rd, flt, lat, mem_is_sign, e.rdata, e.fault, e.lat);
    end
  endtask

  task automatic test_byte_ext();
    bit got; logic [31:0] rd; logic flt; int lat; exp_t e;
    vec_t v[4];
    v[0] = '{1'b0, 1'b0, 32'h0100_0010, 32'h0, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0, 2};
    v[1] = '{1'b0, 1'b0, 32'h0100_0010, 32'h0, 2'b00, 1'b0, 32'h0000_0080, 1'b0, 2};
    v[2] = '{1'b0, 1'b0, 32'h0100_0020, 32'h0, 2'b01, 1'b1, 32'hFFFF_9234, 1'b0, 2};
    v[3] = '{1'b0, 1'b0, 32'h0100_0020, 32'h0, 2'b01, 1'b0, 32'h0000_9234, 1'b0, 2};
    preload(16'h10, 8'h80);
    preload(16'h20, 8'h34);
    preload(16'h21, 8'h92);
    for (int i = 0; i < 4; i++) begin
      issue(v[i]);
      wait_resp(1'b0, got, rd, flt, lat);
      e = sb.pop_front();
      total++;
      if (!got || rd !== e.rdata || flt !== e.fault || lat != e.lat) begin
        bad++; $display("FAIL ext_%0d: got v=%b rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", i, got, rd, flt, lat, e.rdata, e.fault, e.lat);
      end
    end
  endtask

  task automatic test_split_load();
    bit got; logic [31:0] rd; logic flt; int lat; exp_t e;
    vec_t v[3];
    v[0] = '{1'b0, 1'b0, 32'h0100_0001, 32'h0, 2'b10, 1'b0, 32'h4433_2211, 1'b0, 5};
    v[1] = '{1'b0, 1'b0, 32'h0100_0031, 32'h0, 2'b01, 1'b1, 32'hFFFF_81FE, 1'b0, 3};
    v[2] = '{1'b0, 1'b0, 32'h0100_0031, 32'h0, 2'b00, 1'b0, 32'h0000_00FE, 1'b0, 2};
    preload(1, 8'h11); preload(2, 8'h22); preload(3, 8'h33); preload(4, 8'h44);
    preload(16'h31, 8'hFE); preload(16'h32, 8'h81);
    for (int i = 0; i < 3; i++) begin
      issue(v[i]);
      wait_resp(1'b0, got, rd, flt, lat);
      e = sb.pop_front();
      total++;
      if (!got || rd !== e.rdata || flt !== e.fault || lat != e.lat) begin
        bad++; $display("FAIL split_load_%0d: got v=%b rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", i, got, rd, flt, lat, e.rdata, e.fault, e.lat);
      end
    end
  endtask

  task automatic test_split_store();
    bit got; logic [31:0] rd; logic flt; int lat; exp_t e; int w0;
    for (int k = 2; k < 6; k++) preload(k, 8'h5A);
    w0 = wr_count;
    issue('{1'b0, 1'b1, 32'h0100_0003, 32'h0000_ABCD, 2'b01, 1'b0, 32'h0, 1'b0, 3});
    wait_resp(1'b0, got, rd, flt, lat);
    e = sb.pop_front();
    total++;
    if (!got || rd !== e.rdata || flt !== e.fault || lat != e.lat) begin
      bad++; $display("FAIL split_store: got v=%b rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", got, rd, flt, lat, e.rdata, e.fault, e.lat);
    end
    total++;
    if (wr_count - w0 != 2 || last_wr_size !== 2'b00) begin
      bad++; $display("FAIL split_store_cycles: got writes=%0d size=%b want 2 00", wr_count - w0, last_wr_size);
    end
    total++;
    if ({mem[5], mem[4], mem[3], mem[2]} !== 32'h5AAB_CD5A) begin
      bad++; $display("FAIL split_store_mem: got %h want 5aabcd5a", {mem[5], mem[4], mem[3], mem[2]});
    end
  endtask

  task automatic test_faults();
    bit got; logic [31:0] rd; logic flt; int lat; exp_t e; int w0;
    vec_t v[10];
    v[0] = '{1'b0, 1'b1, 32'h00FF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1};
    v[1] = '{1'b0, 1'b1, 32'h010F_FFFE, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1};
    v[2] = '{1'b0, 1'b1, 32'h0100_0000, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'h0, 1'b1, 1};
    v[3] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1};
    v[4] = '{1'b0, 1'b0, 32'h00FF_FFFF, 32'h0,         2'b00, 1'b1, 32'h0, 1'b1, 1};
    v[5] = '{1'b0, 1'b0, 32'h010F_FFFC, 32'h0,         2'b10, 1'b0, 32'h0, 1'b0, 2};
    v[6] = '{1'b0, 1'b1, 32'h010F_FFFF, 32'h0000_0077, 2'b00, 1'b0, 32'h0, 1'b0, 2};
    v[7] = '{1'b1, 1'b1, 32'h0100_0001, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1};
    v[8] = '{1'b1, 1'b0, 32'h0100_0003, 32'h0,         2'b01, 1'b1, 32'h0, 1'b1, 1};
    v[9] = '{1'b1, 1'b0, 32'h0100_0000, 32'h0,         2'b10, 1'b0, 32'h0, 1'b0, 2};
    w0 = wr_count;
    for (int i = 0; i < 10; i++) begin
      issue(v[i]);
      wait_resp(v[i].ns, got, rd, flt, lat);
      e = sb.pop_front();
      total++;
      if (!got || rd !== e.rdata || flt !== e.fault || lat != e.lat) begin
        bad++; $display("FAIL fault_%0d: got v=%b rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", i, got, rd, flt, lat, e.rdata, e.fault, e.lat);
      end
    end
    total++;
    if (wr_count - w0 != 1 || ns_wr_count != 0) begin
      bad++; $display("FAIL fault_writes: got writes=%0d ns_writes=%0d want 1 0", wr_count - w0, ns_wr_count);
    end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0, n_resp = 0;
    int rc[2];
    exp_t e;
    req_store = 1'b0; req_addr = 32'h0100_0010; req_wdata = '0; req_size = 2'b00; req_signed = 1'b0;
    sb.push_back('{32'h0000_0080, 1'b0, 2});
    sb.push_back('{32'h0000_0080, 1'b0, 2});
    @(negedge clock);
    req_valid = 1'b1;
    for (int i = 0; i < 20 && n_resp < 2; i++) begin
      @(negedge clock);
      if (resp_valid && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (resp_rdata !== e.rdata || resp_fault !== e.fault) begin
          bad++; $display("FAIL b2b_resp_%0d: got rd=%h f=%b want rd=%h f=%b", n_resp, resp_rdata, resp_fault, e.rdata, e.fault);
        end
        rc[n_resp] = cyc;
        n_resp++;
      end
      if (req_ready && req_valid) begin
        n_acc++;
        if (n_acc == 2) begin
          @(posedge clock); #1;
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    total++;
    if (n_resp != 2 || rc[1] - rc[0] != 3) begin
      bad++; $display("FAIL b2b_spacing: got responses=%0d gap=%0d want 2 3", n_resp, (n_resp == 2) ? rc[1] - rc[0] : -1);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_split();
    logic [37:0] ctl;
    int seen = 0;
    for (int k = 16'h41; k < 16'h45; k++) preload(k, 8'h00);
    issue('{1'b0, 1'b1, 32'h0100_0041, 32'h4433_2211, 2'b10, 1'b0, 32'h0, 1'b0, 5});
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    ctl = {req_ready, resp_valid, mem_read_write, mem_access_size, mem_address, resp_fault};
    total++;
    if (ctl !== 38'b0) begin bad++; $display("FAIL reset_abort: got %h want 0", ctl); end
    sb.delete();
    repeat (2) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    repeat (6) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_no_resp: got %0d responses want 0", seen); end
    total++;
    if (mem[8'h41] !== 8'h11 || mem[8'h43] !== 8'h00 || mem[8'h44] !== 8'h00) begin
      bad++; $display("FAIL reset_mem: got %h %h %h want 11 00 00", mem[8'h41], mem[8'h43], mem[8'h44]);
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; ns_req_valid = 1'b0; req_store = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = 2'b00; req_signed = 1'b0;
    test_reset();
    test_aligned();
    test_byte_ext();
    test_split_load();
    test_split_store();
    test_faults();
    test_back_to_back();
    test_reset_mid_split();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
